// File: rtl/dsc_mul_seq.sv
// Operand sequencer and result capture stage for the dsc_mul stochastic multiplier.
// Accepts a triple, clears and runs the multiplier until ov, then hands the result downstream.
module dsc_mul_seq #(
  parameter int NUM_BITS   = 8,
  parameter int NUM_INPUTS = 3,
  parameter int CYC_W      = 26,
  parameter int TIMEOUT    = 16777232
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_BITS-1:0]            in_a,
  input  logic [NUM_BITS-1:0]            in_b,
  input  logic [NUM_BITS-1:0]            in_c,
  output logic                           mul_rst,
  output logic                           mul_en,
  output logic [NUM_BITS-1:0]            mul_a,
  output logic [NUM_BITS-1:0]            mul_b,
  output logic [NUM_BITS-1:0]            mul_c,
  input  logic [NUM_INPUTS*NUM_BITS-1:0] mul_z,
  input  logic                           mul_ov,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_INPUTS*NUM_BITS-1:0] out_z,
  output logic [CYC_W-1:0]               out_cycles,
  output logic                           out_err
);

  localparam int ZW = NUM_INPUTS * NUM_BITS;
  localparam logic [CYC_W-1:0] TIMEOUT_C = CYC_W'(TIMEOUT);
  localparam logic [CYC_W-1:0] CNT_MAX   = {CYC_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] mul_a_q, mul_a_d;
  logic [NUM_BITS-1:0] mul_b_q, mul_b_d;
  logic [NUM_BITS-1:0] mul_c_q, mul_c_d;
  logic [CYC_W-1:0]    cnt_q, cnt_d;
  logic [CYC_W-1:0]    cnt_inc_s;
  logic [ZW-1:0]       out_z_q, out_z_d;
  logic [CYC_W-1:0]    out_cycles_q, out_cycles_d;
  logic                out_err_q, out_err_d;
  logic                out_valid_q, out_valid_d;
  logic                mul_rst_q, mul_rst_d;
  logic                mul_en_q, mul_en_d;
  logic                any_zero_s;

  assign any_zero_s = (in_a == {NUM_BITS{1'b0}}) || (in_b == {NUM_BITS{1'b0}}) ||
                      (in_c == {NUM_BITS{1'b0}});
  // Saturating increment so a stuck multiplier can never wrap the count.
  assign cnt_inc_s  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CYC_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_c_d      = mul_c_q;
    cnt_d        = cnt_q;
    out_z_d      = out_z_q;
    out_cycles_d = out_cycles_q;
    out_err_d    = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          mul_c_d = in_c;
          cnt_d   = {CYC_W{1'b0}};
          if (any_zero_s) begin
            state_d      = DONE;
            out_z_d      = {ZW{1'b0}};
            out_cycles_d = {CYC_W{1'b0}};
            out_err_d    = 1'b0;
          end else begin
            state_d = CLR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CLR: begin
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc_s;
        // ov wins over timeout when both land on the same cycle.
        if (mul_ov) begin
          state_d = SETTLE;
        end else if (cnt_inc_s >= TIMEOUT_C) begin
          state_d      = DONE;
          out_z_d      = {ZW{1'b0}};
          out_cycles_d = TIMEOUT_C;
          out_err_d    = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      SETTLE: begin
        state_d      = DONE;
        out_z_d      = mul_z;
        out_cycles_d = cnt_q;
        out_err_d    = 1'b0;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Control outputs are decoded from the next state so they register in step with it.
    mul_rst_d   = (state_d == IDLE) || (state_d == CLR);
    mul_en_d    = (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mul_a_q      <= {NUM_BITS{1'b0}};
      mul_b_q      <= {NUM_BITS{1'b0}};
      mul_c_q      <= {NUM_BITS{1'b0}};
      cnt_q        <= {CYC_W{1'b0}};
      out_z_q      <= {ZW{1'b0}};
      out_cycles_q <= {CYC_W{1'b0}};
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      mul_rst_q    <= 1'b1;
      mul_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_c_q      <= mul_c_d;
      cnt_q        <= cnt_d;
      out_z_q      <= out_z_d;
      out_cycles_q <= out_cycles_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
      mul_rst_q    <= mul_rst_d;
      mul_en_q     <= mul_en_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign mul_rst    = mul_rst_q;
  assign mul_en     = mul_en_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_c      = mul_c_q;
  assign out_valid  = out_valid_q;
  assign out_z      = out_z_q;
  assign out_cycles = out_cycles_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// Scoreboard bench for dsc_mul_seq with a behavioural multiplier stub whose
// latency is a simple function of the operands and which can be made to hang.
module tb_dsc_mul_seq;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b, in_c;
  logic        mul_rst, mul_en;
  logic [7:0]  mul_a, mul_b, mul_c;
  logic [23:0] mul_z;
  logic        mul_ov;
  logic        out_valid, out_ready;
  logic [23:0] out_z;
  logic [25:0] out_cycles;
  logic        out_err;

  dsc_mul_seq #(.NUM_BITS(8), .NUM_INPUTS(3), .CYC_W(26), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .mul_rst(mul_rst), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .mul_z(mul_z), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cycles(out_cycles), .out_err(out_err)
  );

  typedef struct {
    logic [23:0] z;
    logic [25:0] cyc;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   tests = 0, failed = 0;
  int   nedge = 0, en_cnt = 0, rst_cnt = 0, hs_nedge = 0, last_acc = 0;
  bit   en_seen = 0, seen = 0, stub_dead = 0;
  int   mode = 0;
  int   st_cnt;

  int va[10] = '{3, 10, 255, 1, 0, 12, 100, 200, 7, 128};
  int vb[10] = '{5, 10, 255, 1, 9, 34, 2, 100, 0, 2};
  int vc[10] = '{7, 10, 255, 1, 9, 56, 3, 50, 0, 64};
  int vz[10] = '{105, 1000, 16581375, 1, 0, 22848, 600, 1000000, 0, 16384};

  function automatic int stub_lat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return int'((a ^ b ^ c) & 8'd7) + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier stub: raises ov (and a valid z) after stub_lat enabled cycles.
  always @(posedge clk) begin
    if (mul_rst) begin
      st_cnt <= 0;
      mul_ov <= 1'b0;
      mul_z  <= 24'd0;
    end else if (mul_en && !mul_ov && !stub_dead) begin
      st_cnt <= st_cnt + 1;
      if (st_cnt + 1 == stub_lat(mul_a, mul_b, mul_c)) begin
        mul_ov <= 1'b1;
        mul_z  <= 24'(mul_a) * 24'(mul_b) * 24'(mul_c);
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops one expectation per presented result and checks it stays stable.
  initial begin
    forever begin
      @(negedge clk);
      nedge++;
      if (mul_en) begin
        en_cnt++;
        en_seen = 1'b1;
      end
      if (mul_rst && !en_seen) rst_cnt++;
      if (rst && out_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 64'(out_valid), 64'(0));
          end else begin
            cur  = q.pop_front();
            seen = 1'b1;
            chk("out_z", 64'(out_z), 64'(cur.z));
            chk("out_cycles", 64'(out_cycles), 64'(cur.cyc));
            chk("out_err", 64'(out_err), 64'(cur.err));
            chk("latency", 64'(nedge - cur.acc), 64'(cur.lat));
            chk("mul_en_cycles", 64'(en_cnt), 64'(cur.cyc));
            if (cur.cyc != 26'd0) chk("mul_rst_before_run", 64'(rst_cnt), 64'(1));
          end
        end else begin
          chk("hold_out_z", 64'(out_z), 64'(cur.z));
          chk("hold_out_cycles", 64'(out_cycles), 64'(cur.cyc));
          chk("hold_in_ready", 64'(in_ready), 64'(0));
        end
        if (out_ready) hs_nedge = nedge;
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [23:0] exp_z);
    exp_t e;
    int   waited;
    bit   zero;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_c = c;
    waited = 0;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 3000) begin
        chk("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    last_acc = nedge;
    en_cnt   = 0;
    rst_cnt  = 0;
    en_seen  = 1'b0;
    zero     = (a == 8'd0) || (b == 8'd0) || (c == 8'd0);
    e.acc    = nedge;
    e.z      = exp_z;
    e.err    = !zero && stub_dead;
    if (zero) begin
      e.cyc = 26'd0;
      e.lat = 1;
    end else if (stub_dead) begin
      e.cyc = 26'd100;
      e.lat = 102;
    end else begin
      e.cyc = 26'(stub_lat(a, b, c) + 1);
      e.lat = stub_lat(a, b, c) + 4;
    end
    q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  initial begin
    exp_t dropped;
    int   n;
    rst = 1'b0;
    in_valid = 1'b0;
    in_a = 8'd0;
    in_b = 8'd0;
    in_c = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_mul_rst", 64'(mul_rst), 64'(1));
    chk("rst_mul_en", 64'(mul_en), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_z", 64'(out_z), 64'(0));
    chk("rst_out_cycles", 64'(out_cycles), 64'(0));
    chk("rst_out_err", 64'(out_err), 64'(0));
    chk("rst_mul_abc", 64'({mul_a, mul_b, mul_c}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    send(8'd2, 8'd3, 8'd4, 24'd24);
    drain();

    send(8'd0, 8'd200, 8'd17, 24'd0);
    @(negedge clk);
    chk("zero_valid_next_cycle", 64'(out_valid), 64'(1));
    drain();

    // Back-pressure: result must hold for 50 cycles and block the next accept.
    mode = 1;
    send(8'd15, 8'd15, 8'd15, 24'd3375);
    fork
      send(8'd1, 8'd2, 8'd3, 24'd6);
      begin
        n = 0;
        while (!out_valid && n < 500) begin
          @(negedge clk);
          n++;
        end
        repeat (50) begin
          @(negedge clk);
          chk("hold_no_accept", 64'(in_ready), 64'(0));
        end
        mode = 0;
      end
    join
    chk("second_accept_edge", 64'(last_acc), 64'(hs_nedge + 1));
    drain();

    stub_dead = 1'b1;
    send(8'd9, 8'd9, 8'd9, 24'd0);
    drain();
    stub_dead = 1'b0;

    send(8'd255, 8'd255, 8'd255, 24'd16581375);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    dropped = q.pop_back();
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_mul_rst", 64'(mul_rst), 64'(1));
    chk("abort_mul_en", 64'(mul_en), 64'(0));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send(8'd1, 8'd1, 8'd5, 24'd5);
    drain();

    mode = 2;
    for (int i = 0; i < 10; i++) begin
      send(8'(va[i]), 8'(vb[i]), 8'(vc[i]), 24'(vz[i]));
    end
    drain();
    mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dsc_mul_seq.md
Name: dsc_mul_seq

Overview:
- Operand sequencer and result capture stage wrapped around dsc_mul (3-input, 8-bit deterministic stochastic multiplier).
- Accepts operand triples over a valid/ready interface and clears the multiplier before each job.
- Enables the multiplier until it raises ov, then captures z plus the enabled-cycle count and presents them downstream over valid/ready.
- Replaces the manual rst/en/wait(ov) sequencing currently done by benches, so dsc_mul can sit in a streaming datapath.

Parameters:
- NUM_BITS, 8, width of each operand.
- NUM_INPUTS, 3, operand count; fixed at 3 for this block, used for result width.
- CYC_W, 26, width of the cycle counter and timeout compare.
- TIMEOUT, 16777232 (2^24+16), maximum RUN cycles before abort.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand triple valid
- in_ready  out  1  sequencer can accept a triple
- in_a, in_b, in_c  in  NUM_BITS  operands
- mul_rst  out  1  to dsc_mul rst, active-high
- mul_en  out  1  to dsc_mul en
- mul_a, mul_b, mul_c  out  NUM_BITS  registered operands to dsc_mul
- mul_z  in  NUM_INPUTS*NUM_BITS  dsc_mul product
- mul_ov  in  1  dsc_mul operation finished
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_z  out  NUM_INPUTS*NUM_BITS  captured product
- out_cycles  out  CYC_W  number of cycles mul_en was high for this job
- out_err  out  1  job aborted by timeout; out_z forced 0

Behaviour:
- Reset (rst=0, async) values:
  - State IDLE; mul_rst=1; mul_en=0.
  - mul_a/b/c, out_z, out_cycles, out_err = 0; out_valid=0.
  - in_ready is decoded from state, so it is 1 while in reset.
- All outputs except in_ready are registered. in_ready = (state==IDLE).
- IDLE:
  - mul_rst=1, mul_en=0.
  - On in_valid&&in_ready, latch in_a/b/c into mul_a/b/c and clear the cycle counter.
  - If any operand is 0: go to DONE with out_z=0, out_cycles=0, out_err=0 (zero fast path; multiplier not run).
  - Otherwise go to CLR.
- CLR: exactly one cycle. mul_rst=1, mul_en=0. Next state RUN.
- RUN:
  - mul_rst=0, mul_en=1; counter increments each cycle.
  - mul_ov sampled 1: go to SETTLE.
  - Counter reaches TIMEOUT with mul_ov=0: go to DONE with out_err=1, out_z=0, out_cycles=TIMEOUT.
  - mul_ov has priority over timeout on the same cycle.
- SETTLE: exactly one cycle. mul_rst=0, mul_en=0. At end of cycle capture out_z=mul_z, out_cycles=counter, out_err=0. Next state DONE.
- DONE:
  - out_valid=1; out_z/out_cycles/out_err held stable.
  - On out_ready=1, clear out_valid and go to IDLE. mul_rst reasserts in IDLE.
  - out_ready is sampled only in DONE; out_ready high before DONE has no effect.
- Latency: accept edge to out_valid = 1 (CLR) + N (RUN cycles, N = out_cycles) + 1 (SETTLE) + 1. Zero fast path is 1 cycle.
- Throughput: one job in flight. in_valid during CLR/RUN/SETTLE/DONE is ignored (in_ready=0); the operands must be held by the upstream stage.
- mul_a/b/c are stable from the accept edge until the next accept.
- Counter saturates at its maximum and never wraps; TIMEOUT < 2^CYC_W.
- rst asserted mid-job: immediate abort to reset values, no partial result emitted. mul_rst=1 holds dsc_mul cleared.
- mul_ov high while in IDLE/CLR is ignored.

Test Plan:
- a=2, b=3, c=4 with the real dsc_mul, out_ready=1 -> one out_valid pulse; out_z=24, out_err=0; out_cycles equals the count of mul_en-high cycles; mul_rst high exactly 1 cycle before RUN.
- a=0, b=200, c=17 -> out_valid exactly 1 cycle after accept; out_z=0, out_cycles=0; mul_en never rises.
- a=b=c=15, out_ready held 0 for 50 cycles after out_valid -> out_z=3375 stable throughout; in_ready=0; a second in_valid is not accepted until the cycle after out_ready=1.
- Stub dsc_mul with mul_ov tied 0, TIMEOUT=100 -> out_valid with out_err=1, out_z=0, out_cycles=100; mul_en high exactly 100 cycles.
- rst pulsed low mid-RUN on job a=b=c=255, then new job a=1, b=1, c=5 -> no out_valid for the aborted job; second job yields out_z=5.
- Ten back-to-back random triples with random out_ready gaps -> each out_z equals a*b*c in order, no job dropped or duplicated.
